csa_seq_ctrl: RTL and testbench

Multi-cycle sequencer that adds WIDTH-bit operands by driving a single 4-bit carry select adder (`csa`: ports a, b, cin, s, cout) one nibble per clock. It processes nibbles from LSB to MSB and carries each nibble's cout into the next. It sits between a requester using a start/busy/done handshake and one instantiated `csa` core, so one small adder serves wide additions.

---
 rtl/csa_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_csa_seq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// csa
//   4-bit carry select adder. The low 2 bits ripple; the high 2 bits are
//   computed for both possible carries in parallel and the low-half carry
//   selects between them.
//   Ports:
//     a, b  - 4-bit addends
//     cin   - carry in
//     s     - 4-bit sum
//     cout  - carry out
// ---------------------------------------------------------------------------
module csa (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;
  logic       w_c2;

  always_comb begin
    w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    w_hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    w_c2  = w_lo[2];
    s     = {(w_c2 ? w_hi1[1:0] : w_hi0[1:0]), w_lo[1:0]};
    cout  = w_c2 ? w_hi1[2] : w_hi0[2];
  end

endmodule

// ---------------------------------------------------------------------------
// csa_seq_ctrl
//   Adds two WIDTH-bit operands one nibble per clock through a single csa
//   instance, LSB nibble first, rippling the carry through a register.
//   WIDTH must be a multiple of 4 and at least 4.
//   Ports:
//     clk    - rising-edge clock
//     rst    - synchronous active-high reset
//     start  - request, accepted only in IDLE or DONE
//     a, b   - operands, captured on an accepted start
//     cin    - carry in, captured on an accepted start
//     busy   - high while the nibble steps are running
//     done   - one-cycle pulse when s/cout hold a new result
//     s      - registered sum
//     cout   - registered final carry out
// ---------------------------------------------------------------------------
module csa_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s_nib;
  logic             w_cout_nib;
  logic [WIDTH-1:0] w_acc_next;

  // Nibble select by compare-per-slot rather than a computed part-select,
  // so the index width never has to match the operand bit-address width.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (r_idx == IW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
  end

  csa u_csa (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s_nib),
    .cout (w_cout_nib)
  );

  // Accumulator with the current nibble merged in; on the last step this is
  // the complete sum and is what lands in s.
  always_comb begin
    w_acc_next = r_acc;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (r_idx == IW'(n)) begin
        w_acc_next[4*n +: 4] = w_s_nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout_nib;
          if (r_idx == LAST) begin
            r_s     <= w_acc_next;
            r_cout  <= w_cout_nib;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Bench for csa_seq_ctrl: a 16-bit and a 4-bit instance. Stimulus pushes
// hand-computed {cout,s} values into per-instance queues; negedge monitors
// pop and compare whenever done is seen.
module tb_csa_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, s16;
  logic        start4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, s4;

  int checks = 0;
  int errors = 0;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];

  csa_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16)
  );

  csa_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      chk("busy_with_done16", {31'd0, busy16}, 32'd0);
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: got s=0x%0h cout=%0d, expected no result", s16, cout16);
      end else begin
        chk("result16", {15'd0, cout16, s16}, {15'd0, q16.pop_front()});
      end
    end
    if (done4 === 1'b1) begin
      chk("busy_with_done4", {31'd0, busy4}, 32'd0);
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4: got s=0x%0h cout=%0d, expected no result", s4, cout4);
      end else begin
        chk("result4", {27'd0, cout4, s4}, {27'd0, q4.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // Waits for done16 at a negedge; bounded.
  task automatic wait_done16(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done16 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (done16 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 30 cycles, expected done", name);
    end
  endtask

  // Full timed operation: busy for 4 cycles from E0, done in the cycle after E4.
  task automatic op16_timed(input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic [16:0] exp);
    a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
    q16.push_back(exp);
    @(posedge clk);
    #1 start16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_run16", {31'd0, busy16}, 32'd1);
      chk("nodone_run16", {31'd0, done16}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_pulse16", {31'd0, done16}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle16", {31'd0, done16}, 32'd0);
    chk("s_hold16", {16'd0, s16}, {16'd0, exp[15:0]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy16", {31'd0, busy16}, 32'd0);
    chk("rst_done16", {31'd0, done16}, 32'd0);
    chk("rst_s16", {16'd0, s16}, 32'd0);
    chk("rst_cout16", {31'd0, cout16}, 32'd0);
    chk("rst_s4", {27'd0, cout4, s4}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic add and full carry propagation
    op16_timed(16'h1234, 16'h4321, 1'b0, 17'h05555);
    op16_timed(16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    op16_timed(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);

    // Start during RUN is ignored
    a16 = 16'h00A5; b16 = 16'h005A; cin16 = 1'b0; start16 = 1'b1;
    q16.push_back(17'h000FF);
    @(posedge clk);
    #1 start16 = 1'b0;
    @(posedge clk);
    #1 a16 = 16'h1111; b16 = 16'h2222; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    wait_done16("ignored_start_done");
    repeat (6) @(negedge clk);
    chk("no_second_op16", {31'd0, busy16}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: start held through the DONE cycle
    a16 = 16'h00A5; b16 = 16'h005A; cin16 = 1'b0; start16 = 1'b1;
    q16.push_back(17'h000FF);
    @(posedge clk);
    #1 a16 = 16'h8000; b16 = 16'h8000;
    q16.push_back(17'h10000);
    wait_done16("b2b_first_done");
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    chk("b2b_rerun_busy16", {31'd0, busy16}, 32'd1);
    wait_done16("b2b_second_done");
    @(posedge clk);
    #1;

    // Reset mid-operation (sampled at E2)
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy16", {31'd0, busy16}, 32'd0);
    chk("midrst_done16", {31'd0, done16}, 32'd0);
    chk("midrst_s16", {16'd0, s16}, 32'd0);
    chk("midrst_cout16", {31'd0, cout16}, 32'd0);
    @(posedge clk);
    #1;
    op16_timed(16'h0FFF, 16'h0001, 1'b0, 17'h01000);

    // WIDTH=4 instance: result one edge after start
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    q4.push_back(5'h1F);
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("busy4", {31'd0, busy4}, 32'd1);
    @(negedge clk);
    chk("done4_latency", {31'd0, done4}, 32'd1);
    @(posedge clk);
    #1 a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0; start4 = 1'b1;
    q4.push_back(5'h0F);
    @(posedge clk);
    #1 a4 = 4'h8; b4 = 4'h8;
    q4.push_back(5'h10);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (4) @(negedge clk);

    chk("q16_drained", q16.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
